// File: rtl/tcni_pkg.sv
// Shared types for the TCNI release-time scheduler: word type, FSM states,
// the flow table entry and the wrap-safe release test.
package tcni_pkg;

   localparam int NI_WORD_LENGTH = 32;

   typedef logic [NI_WORD_LENGTH-1:0] word;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_ISSUE,
      S_BUSY
   } sched_state_t;

   typedef struct packed {
      logic enable;
      word  offset;
      word  period;
      word  addr;
      word  len;
      word  next_rel;
   } flow_slot_t;

   // Due when the signed distance from the release instant is non-negative,
   // so the comparison stays correct across time base wrap.
   function automatic logic release_due(input logic enable, input word now, input word next_rel);
      word diff;
      diff = now - next_rel;
      return enable && !diff[NI_WORD_LENGTH-1];
   endfunction

endpackage

// File: rtl/tcni_rr_picker.sv
// Combinational round-robin picker: searches the due vector starting at the
// slot after the last grant and returns the first due slot.
module tcni_rr_picker #(
   parameter int NUM_FLOWS = 4
) (
   input  logic [NUM_FLOWS-1:0]         due,
   input  logic [$clog2(NUM_FLOWS)-1:0] last,
   output logic [$clog2(NUM_FLOWS)-1:0] grant,
   output logic                         valid
);

   localparam int FW = $clog2(NUM_FLOWS);

   logic [FW-1:0] idx;

   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      for (int unsigned i = 1; i <= NUM_FLOWS; i++) begin
         idx = last + FW'(i);
         if (!valid && due[idx]) begin
            grant = idx;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tcni_scheduler.sv
// Release-time scheduler for the TCNI DMA: a table of periodic flows against a
// free-running time base, issuing one serialized burst request per release.
module tcni_scheduler
   import tcni_pkg::*;
#(
   parameter int NUM_FLOWS = 4,
   parameter int LEN_W     = 16
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         cfg_we,
   input  logic [$clog2(NUM_FLOWS)-1:0] cfg_flow,
   input  logic                         cfg_enable,
   input  logic [31:0]                  cfg_offset,
   input  logic [31:0]                  cfg_period,
   input  logic [31:0]                  cfg_addr,
   input  logic [LEN_W-1:0]             cfg_len,
   input  logic                         start,
   input  logic                         stop,
   output logic                         running,
   output logic                         cfg_err,
   output logic [31:0]                  now,
   output logic                         req_valid,
   input  logic                         req_ready,
   output logic [31:0]                  req_addr,
   output logic [LEN_W-1:0]             req_len,
   output logic [$clog2(NUM_FLOWS)-1:0] req_flow,
   input  logic                         dma_done,
   output logic [NUM_FLOWS-1:0]         overrun,
   input  logic                         overrun_clr
);

   localparam int FW = $clog2(NUM_FLOWS);

   sched_state_t   state;
   flow_slot_t     slots [NUM_FLOWS];
   logic [FW-1:0]  rr_ptr;
   logic           stop_pend;

   logic [NUM_FLOWS-1:0] due;
   logic [FW-1:0]        last_grant;
   logic [FW-1:0]        pick;
   logic                 pick_valid;
   word                  cur_period;
   word                  cur_next;
   word                  late;

   always_comb begin
      due = '0;
      for (int unsigned i = 0; i < NUM_FLOWS; i++) begin
         due[i] = release_due(slots[i].enable, now, slots[i].next_rel);
      end
   end

   // rr_ptr holds the first-priority slot; the picker wants the last grant.
   assign last_grant = rr_ptr - FW'(1);

   tcni_rr_picker #(
      .NUM_FLOWS (NUM_FLOWS)
   ) u_picker (
      .due   (due),
      .last  (last_grant),
      .grant (pick),
      .valid (pick_valid)
   );

   assign cur_period = slots[req_flow].period;
   assign cur_next   = slots[req_flow].next_rel;
   assign late       = now - cur_next;
   assign running    = (state != S_IDLE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         now       <= '0;
         rr_ptr    <= '0;
         stop_pend <= 1'b0;
         cfg_err   <= 1'b0;
         overrun   <= '0;
         req_valid <= 1'b0;
         req_addr  <= '0;
         req_len   <= '0;
         req_flow  <= '0;
         for (int unsigned i = 0; i < NUM_FLOWS; i++) begin
            slots[i] <= '0;
         end
      end else begin
         if (overrun_clr) begin
            overrun <= '0;
            cfg_err <= 1'b0;
         end

         if (cfg_we) begin
            if (state == S_IDLE) begin
               slots[cfg_flow].enable <= cfg_enable;
               slots[cfg_flow].offset <= cfg_offset;
               slots[cfg_flow].period <= cfg_period;
               slots[cfg_flow].addr   <= cfg_addr;
               slots[cfg_flow].len    <= word'(cfg_len);
            end else begin
               cfg_err <= 1'b1;
            end
         end

         if (stop && state != S_IDLE) stop_pend <= 1'b1;
         if (state != S_IDLE) now <= now + 32'd1;

         case (state)
            S_IDLE: begin
               if (start) begin
                  now       <= '0;
                  stop_pend <= 1'b0;
                  for (int unsigned i = 0; i < NUM_FLOWS; i++) begin
                     slots[i].next_rel <= slots[i].offset;
                  end
                  state <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (stop_pend) begin
                  state <= S_IDLE;
               end else if (pick_valid) begin
                  req_addr  <= slots[pick].addr;
                  req_len   <= slots[pick].len[LEN_W-1:0];
                  req_flow  <= pick;
                  req_valid <= 1'b1;
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (req_ready) begin
                  // Overrun set is placed after the clear so a same-cycle set wins.
                  if (cur_period != '0 && late >= cur_period) overrun[req_flow] <= 1'b1;
                  slots[req_flow].next_rel <= cur_next + cur_period;
                  if (cur_period == '0) slots[req_flow].enable <= 1'b0;
                  rr_ptr    <= req_flow + FW'(1);
                  req_valid <= 1'b0;
                  state     <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (dma_done) state <= S_SCAN;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tcni_scheduler.sv
// Scoreboard bench for tcni_scheduler: expected requests (time, flow, addr, len)
// are queued with the stimulus and compared at each accepted handshake.
module tb_tcni_scheduler;

   localparam int NF = 4;
   localparam int LW = 16;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          cfg_we = 1'b0;
   logic [1:0]    cfg_flow = '0;
   logic          cfg_enable = 1'b0;
   logic [31:0]   cfg_offset = '0;
   logic [31:0]   cfg_period = '0;
   logic [31:0]   cfg_addr = '0;
   logic [LW-1:0] cfg_len = '0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          running;
   logic          cfg_err;
   logic [31:0]   now;
   logic          req_valid;
   logic          req_ready = 1'b1;
   logic [31:0]   req_addr;
   logic [LW-1:0] req_len;
   logic [1:0]    req_flow;
   logic          dma_done;
   logic [NF-1:0] overrun;
   logic          overrun_clr = 1'b0;

   logic resp_done = 1'b0;
   logic stray_done = 1'b0;
   assign dma_done = resp_done | stray_done;

   always #5 clock = ~clock;

   tcni_scheduler #(
      .NUM_FLOWS (NF),
      .LEN_W     (LW)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .cfg_we      (cfg_we),
      .cfg_flow    (cfg_flow),
      .cfg_enable  (cfg_enable),
      .cfg_offset  (cfg_offset),
      .cfg_period  (cfg_period),
      .cfg_addr    (cfg_addr),
      .cfg_len     (cfg_len),
      .start       (start),
      .stop        (stop),
      .running     (running),
      .cfg_err     (cfg_err),
      .now         (now),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_len     (req_len),
      .req_flow    (req_flow),
      .dma_done    (dma_done),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   typedef struct {
      int unsigned   t;
      int unsigned   flow;
      logic [31:0]   addr;
      logic [LW-1:0] len;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   hs_count = 0;
   int   dly = 5;
   int   timer = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic expect_req(input int unsigned t, input int unsigned f,
                             input logic [31:0] a, input logic [LW-1:0] l);
      sb.push_back('{t, f, a, l});
   endtask

   // Monitor and DMA model: compare at each handshake, then pulse dma_done
   // 'dly' cycles after the handshake cycle.
   initial begin : mon
      exp_t e;
      forever begin
         @(negedge clock);
         if (reset && req_valid && req_ready) begin
            hs_count++;
            if (sb.size() == 0) begin
               check_eq("req_expected", 64'(sb.size()), 64'd1);
            end else begin
               e = sb.pop_front();
               check_eq("req_now",  64'(now),      64'(e.t));
               check_eq("req_flow", 64'(req_flow), 64'(e.flow));
               check_eq("req_addr", 64'(req_addr), 64'(e.addr));
               check_eq("req_len",  64'(req_len),  64'(e.len));
            end
            timer = dly;
         end
         @(posedge clock);
         #1;
         if (timer > 0) begin
            timer--;
            resp_done = (timer == 0);
         end else begin
            resp_done = 1'b0;
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(1);
   endtask

   task automatic cfg_slot(input int f, input logic en, input logic [31:0] off,
                           input logic [31:0] per, input logic [31:0] addr,
                           input logic [LW-1:0] len);
      cfg_flow   = 2'(f);
      cfg_enable = en;
      cfg_offset = off;
      cfg_period = per;
      cfg_addr   = addr;
      cfg_len    = len;
      cfg_we     = 1'b1;
      tick();
      cfg_we     = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task automatic pulse_clr();
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
   endtask

   task automatic wait_hs(input int target, input int budget);
      int k = 0;
      while (hs_count < target && k < budget) begin
         tick();
         k++;
      end
      check_eq("hs_count", 64'(hs_count), 64'(target));
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (running && k < budget) begin
         tick();
         k++;
      end
      check_eq("running_idle", 64'(running), 64'd0);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int base;
      int k;

      // Reset values
      tick(2);
      check_eq("rst_running",   64'(running),   64'd0);
      check_eq("rst_now",       64'(now),       64'd0);
      check_eq("rst_req_valid", 64'(req_valid), 64'd0);
      check_eq("rst_req_addr",  64'(req_addr),  64'd0);
      check_eq("rst_req_len",   64'(req_len),   64'd0);
      check_eq("rst_req_flow",  64'(req_flow),  64'd0);
      check_eq("rst_overrun",   64'(overrun),   64'd0);
      check_eq("rst_cfg_err",   64'(cfg_err),   64'd0);
      reset = 1'b1;
      tick();

      // Single periodic flow: releases at 10, 60, 110 -> handshakes one cycle later
      do_reset();
      dly = 5;
      cfg_slot(0, 1'b1, 32'd10, 32'd50, 32'h1000, 16'd8);
      base = hs_count;
      for (int i = 0; i < 3; i++) expect_req(11 + 50 * i, 0, 32'h1000, 16'd8);
      pulse_start();
      wait_hs(base + 3, 400);
      pulse_stop();
      wait_idle(50);
      check_eq("s1_overrun", 64'(overrun), 64'd0);
      check_eq("s1_sb_empty", 64'(sb.size()), 64'd0);

      // Two flows due together: round-robin 0,1 then 0,1
      do_reset();
      dly = 20;
      cfg_slot(0, 1'b1, 32'd0, 32'd100, 32'h2000, 16'd4);
      cfg_slot(1, 1'b1, 32'd0, 32'd100, 32'h3000, 16'd6);
      base = hs_count;
      expect_req(1,   0, 32'h2000, 16'd4);
      expect_req(23,  1, 32'h3000, 16'd6);
      expect_req(101, 0, 32'h2000, 16'd4);
      expect_req(123, 1, 32'h3000, 16'd6);
      pulse_start();
      wait_hs(base + 4, 400);
      pulse_stop();
      wait_idle(60);
      check_eq("s2_sb_empty", 64'(sb.size()), 64'd0);

      // Late completion: overrun and back-to-back catch-up
      do_reset();
      dly = 45;
      cfg_slot(0, 1'b1, 32'd0, 32'd20, 32'h5000, 16'd3);
      base = hs_count;
      expect_req(1,  0, 32'h5000, 16'd3);
      expect_req(48, 0, 32'h5000, 16'd3);
      expect_req(95, 0, 32'h5000, 16'd3);
      pulse_start();
      wait_hs(base + 1, 50);
      check_eq("s3_overrun_first", 64'(overrun), 64'd0);
      wait_hs(base + 2, 100);
      check_eq("s3_overrun_set", 64'(overrun), 64'd1);
      wait_hs(base + 3, 100);
      pulse_stop();
      wait_idle(100);
      check_eq("s3_overrun_sticky", 64'(overrun), 64'd1);
      pulse_clr();
      check_eq("s3_overrun_clr", 64'(overrun), 64'd0);
      check_eq("s3_sb_empty", 64'(sb.size()), 64'd0);

      // One-shot flow
      do_reset();
      dly = 5;
      cfg_slot(0, 1'b1, 32'd5, 32'd0, 32'h6000, 16'd1);
      base = hs_count;
      expect_req(6, 0, 32'h6000, 16'd1);
      pulse_start();
      wait_hs(base + 1, 50);
      tick(1000);
      check_eq("s4_one_shot_count", 64'(hs_count), 64'(base + 1));
      check_eq("s4_no_req_valid", 64'(req_valid), 64'd0);
      pulse_stop();
      wait_idle(10);

      // Stop in BUSY and dropped config write while running
      do_reset();
      dly = 10;
      cfg_slot(0, 1'b1, 32'd0, 32'd30, 32'h7000, 16'd5);
      base = hs_count;
      expect_req(1, 0, 32'h7000, 16'd5);
      pulse_start();
      wait_hs(base + 1, 20);
      pulse_stop();
      check_eq("s5_running_busy", 64'(running), 64'd1);
      cfg_slot(1, 1'b1, 32'd0, 32'd0, 32'h8000, 16'd9);
      check_eq("s5_cfg_err", 64'(cfg_err), 64'd1);
      wait_idle(40);
      tick(3);
      check_eq("s5_now_held", 64'(now), 64'd13);
      pulse_clr();
      check_eq("s5_cfg_err_clr", 64'(cfg_err), 64'd0);
      // Slot 1 would win round-robin here had the write been taken
      expect_req(1, 0, 32'h7000, 16'd5);
      pulse_start();
      wait_hs(base + 2, 20);
      pulse_stop();
      wait_idle(40);
      check_eq("s5_sb_empty", 64'(sb.size()), 64'd0);

      // Reset while in ISSUE
      do_reset();
      req_ready = 1'b0;
      cfg_slot(2, 1'b1, 32'd3, 32'd10, 32'h4000, 16'd12);
      pulse_start();
      k = 0;
      while (!req_valid && k < 20) begin
         tick();
         k++;
      end
      check_eq("s6_rise_now", 64'(now), 64'd4);
      check_eq("s6_flow", 64'(req_flow), 64'd2);
      tick(3);
      check_eq("s6_valid_held", 64'(req_valid), 64'd1);
      check_eq("s6_addr_stable", 64'(req_addr), 64'h4000);
      check_eq("s6_len_stable", 64'(req_len), 64'd12);
      #2;
      reset = 1'b0;
      #1;
      check_eq("s6_rst_running",   64'(running),   64'd0);
      check_eq("s6_rst_now",       64'(now),       64'd0);
      check_eq("s6_rst_req_valid", 64'(req_valid), 64'd0);
      check_eq("s6_rst_req_addr",  64'(req_addr),  64'd0);
      check_eq("s6_rst_req_len",   64'(req_len),   64'd0);
      check_eq("s6_rst_req_flow",  64'(req_flow),  64'd0);
      tick();
      reset = 1'b1;
      req_ready = 1'b1;
      stray_done = 1'b1;
      tick();
      stray_done = 1'b0;
      tick(5);
      check_eq("s6_stray_running", 64'(running), 64'd0);
      check_eq("s6_stray_valid", 64'(req_valid), 64'd0);
      check_eq("s6_stray_now", 64'(now), 64'd0);
      check_eq("s6_sb_empty", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
